// File: rtl/fifo_reader_if.sv
// Read-side bundle for fifo_reader: FIFO read port plus the downstream valid/ready channel.
// The master modport is the controller; the slave modport is the FIFO and consumer side.
interface fifo_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  empty;
    logic                  rd_en;
    logic                  rd_ack;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  empty, rd_ack, rd_err, fifo_dout, out_ready,
        output rd_en, out_data, out_valid
    );

    modport slave (
        output empty, rd_ack, rd_err, fifo_dout, out_ready,
        input  rd_en, out_data, out_valid
    );
endinterface

// File: rtl/fifo_reader.sv
// Pulls one word at a time from the FIFO and hands it downstream over valid/ready,
// counting failed reads (saturating) and delivered words (wrapping).
//
// state  | meaning
// S_IDLE | waiting for enable & !empty
// S_REQ  | rd_en pulse to the FIFO
// S_WAIT | FIFO response cycle: capture on rd_ack, count errors
// S_HOLD | word presented downstream until out_ready
module fifo_reader #(
    parameter int DATA_WIDTH     = 32,
    parameter int ERR_CNT_WIDTH  = 8,
    parameter int WORD_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    fifo_reader_if.master             bus,
    output logic                      busy,
    output logic [ERR_CNT_WIDTH-1:0]  err_count,
    output logic [WORD_CNT_WIDTH-1:0] word_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_HOLD = 2'b11
    } state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic [ERR_CNT_WIDTH-1:0]  err_count_q, err_count_d;
    logic [WORD_CNT_WIDTH-1:0] word_count_q, word_count_d;
    logic                      err_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;
        err_inc      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && !bus.empty) state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // rd_ack wins; a missing response is treated as a failed read
                if (bus.rd_ack) begin
                    out_data_d  = bus.fifo_dout;
                    out_valid_d = 1'b1;
                    err_inc     = bus.rd_err;
                    state_d     = S_HOLD;
                end else begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    word_count_d = word_count_q + 1'b1;
                    out_valid_d  = 1'b0;
                    state_d      = (enable && !bus.empty) ? S_REQ : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (err_inc && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
    end

    assign bus.rd_en     = (state_q == S_REQ);
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = (state_q != S_IDLE);
    assign err_count     = err_count_q;
    assign word_count    = word_count_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: behavioural FIFO and consumer, word scoreboard, and
// transaction-level rules for read pulses, hold stability, latency and counters.
module tb_fifo_reader;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        busy;
    logic [7:0]  err_count;
    logic [15:0] word_count;

    fifo_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_reader #(
        .DATA_WIDTH(DW),
        .ERR_CNT_WIDTH(8),
        .WORD_CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .bus(bus.master),
        .busy(busy),
        .err_count(err_count),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int exp_errs = 0;
    int n_hs = 0;
    int cyc = 0;
    int rd_count = 0;
    int last_rd_cyc = -100;
    bit resp_active = 0;
    bit space_chk = 0;
    bit rnd_mode = 0;
    bit saw_valid = 0;
    int resp_mode = 0;  // 0 normal, 1 rd_err only, 2 no response, 3 rd_ack+rd_err
    logic [31:0] last_word = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        bus.empty = 1'b0;
    endtask

    // One clock: inputs held across the edge are noted first, then effects are applied
    task automatic cycle();
        bit rd_now, hs_now, err_now, rst_now, hold_now, cause_now, valid_prev;
        logic [31:0] data_prev;
        int sat, r;
        rd_now     = bus.rd_en;
        hs_now     = bus.out_valid && bus.out_ready;
        hold_now   = bus.out_valid && !bus.out_ready;
        err_now    = resp_active && (!bus.rd_ack || bus.rd_err);
        rst_now    = reset;
        cause_now  = enable && !bus.empty;
        valid_prev = bus.out_valid;
        data_prev  = bus.out_data;

        @(posedge clk);
        #1;
        cyc++;
        bus.rd_ack  = 1'b0;
        bus.rd_err  = 1'b0;
        resp_active = 1'b0;

        if (rst_now) begin
            exp_errs = 0;
            n_hs = 0;
            exp_q.delete();
            last_rd_cyc = -100;
            chk("rst_rd_en", bus.rd_en, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data", bus.out_data, 0);
        end else begin
            if (err_now) exp_errs++;
            if (hs_now) begin
                n_hs++;
                chk("hs_word_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    last_word = exp_q.pop_front();
                    chk("hs_data", data_prev, last_word);
                end
            end
            if (rd_now) begin
                resp_active = 1'b1;
                case (resp_mode)
                    1: bus.rd_err = 1'b1;
                    2: ;
                    default: begin
                        if (fifo_q.size() > 0) begin
                            bus.fifo_dout = fifo_q.pop_front();
                            bus.rd_ack = 1'b1;
                            exp_q.push_back(bus.fifo_dout);
                            if (resp_mode == 3) bus.rd_err = 1'b1;
                        end else begin
                            bus.rd_err = 1'b1;
                        end
                    end
                endcase
                chk("wait_no_rd", bus.rd_en, 0);
                chk("wait_no_valid", bus.out_valid, 0);
            end
            if (hold_now) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, data_prev);
                chk("hold_no_rd", bus.rd_en, 0);
            end
            if (bus.rd_en) begin
                rd_count++;
                chk("rd_cause", cause_now, 1);
                chk("rd_single_pulse", rd_now, 0);
                if (space_chk && last_rd_cyc >= 0) chk("rd_space", cyc - last_rd_cyc, 3);
                last_rd_cyc = cyc;
            end
            if (!valid_prev && bus.out_valid) chk("valid_latency", cyc - last_rd_cyc, 2);
        end

        if (bus.out_valid) saw_valid = 1'b1;
        sat = (exp_errs > 255) ? 255 : exp_errs;
        chk("err_count", err_count, sat);
        chk("word_count", word_count, n_hs % 65536);
        chk("busy", busy, bus.rd_en || bus.out_valid || resp_active);

        if (rnd_mode) begin
            if (fifo_q.size() < 8 && $urandom_range(0, 2) == 0) fifo_q.push_back($urandom);
            enable = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 19);
            resp_mode = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
        end
        bus.empty = (fifo_q.size() == 0);
    endtask

    task automatic drain(input string tag, input int limit);
        int n = 0;
        while (((!bus.empty && enable) || busy || bus.rd_en) && n < limit) begin
            cycle();
            n++;
        end
        chk(tag, n < limit, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int n, h0, r0, e0;
        reset = 1'b1;
        enable = 1'b0;
        bus.empty = 1'b1;
        bus.rd_ack = 1'b0;
        bus.rd_err = 1'b0;
        bus.fifo_dout = '0;
        bus.out_ready = 1'b1;

        // Reset held with a loaded FIFO and enable high
        for (int i = 0; i < 5; i++) push(32'h100 + i);
        enable = 1'b1;
        repeat (3) cycle();
        chk("rst_busy", busy, 0);
        chk("rst_err", err_count, 0);
        chk("rst_words", word_count, 0);
        reset = 1'b0;
        n = 0;
        while (!bus.rd_en && n < 10) begin
            cycle();
            n++;
        end
        chk("first_rd_latency", n, 1);
        drain("drain5_timeout", 100);
        chk("drain5_words", word_count, 5);

        // Single word
        r0 = rd_count;
        push(32'hDEADBEEF);
        drain("single_timeout", 50);
        chk("single_rd_pulses", rd_count - r0, 1);
        chk("single_words", word_count, 6);
        chk("single_empty", bus.empty, 1);
        chk("single_idle", busy, 0);

        // Full drain of 8 words with spacing checks
        enable = 1'b0;
        for (int i = 1; i <= 8; i++) push(i);
        cycle();
        h0 = n_hs;
        space_chk = 1'b1;
        last_rd_cyc = -100;
        enable = 1'b1;
        drain("drain8_timeout", 100);
        space_chk = 1'b0;
        chk("drain8_words", word_count, 14);
        chk("drain8_errs", err_count, 0);

        // Backpressure
        enable = 1'b0;
        bus.out_ready = 1'b0;
        push(32'hB0B0_0001);
        push(32'hB0B0_0002);
        enable = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            cycle();
            n++;
        end
        chk("bp_valid_timeout", n < 10, 1);
        r0 = rd_count;
        repeat (10) cycle();
        chk("bp_no_second_rd", rd_count - r0, 0);
        chk("bp_data_held", bus.out_data, 32'hB0B0_0001);
        bus.out_ready = 1'b1;
        drain("bp_timeout", 50);
        chk("bp_words", word_count, 16);

        // rd_ack with rd_err, then a missing response
        e0 = err_count;
        resp_mode = 3;
        push(32'hC0C0_0003);
        drain("ackerr_timeout", 50);
        chk("ackerr_err", err_count, e0 + 1);
        chk("ackerr_words", word_count, 17);
        resp_mode = 2;
        push(32'hC0C0_0004);
        r0 = rd_count;
        n = 0;
        while (rd_count == r0 && n < 10) begin
            cycle();
            n++;
        end
        enable = 1'b0;
        cycle();
        cycle();
        resp_mode = 0;
        chk("noresp_err", err_count, e0 + 2);
        chk("noresp_valid", bus.out_valid, 0);
        enable = 1'b1;
        drain("noresp_timeout", 50);
        chk("noresp_words", word_count, 18);

        // Randomized traffic
        do_reset();
        rnd_mode = 1'b1;
        repeat (2000) cycle();
        rnd_mode = 1'b0;
        resp_mode = 0;
        enable = 1'b1;
        bus.out_ready = 1'b1;
        drain("rnd_timeout", 200);
        chk("rnd_all_delivered", exp_q.size(), 0);

        // Error counter saturation
        enable = 1'b0;
        fifo_q.delete();
        bus.empty = 1'b1;
        do_reset();
        push(32'hA5A5_0F0F);
        enable = 1'b1;
        drain("sat_pre_timeout", 50);
        push(32'hDEAD_0000);
        resp_mode = 1;
        saw_valid = 1'b0;
        n = 0;
        while (exp_errs < 300 && n < 3000) begin
            cycle();
            n++;
        end
        chk("sat_timeout", n < 3000, 1);
        enable = 1'b0;
        cycle();
        cycle();
        resp_mode = 0;
        chk("err_saturated", err_count, 8'hFF);
        chk("sat_no_valid", saw_valid, 0);
        chk("sat_data_kept", bus.out_data, 32'hA5A5_0F0F);

        // Reset while the FIFO response is in flight
        enable = 1'b1;
        n = 0;
        while (!resp_active && n < 10) begin
            cycle();
            n++;
        end
        chk("midrst_wait_timeout", n < 10, 1);
        chk("midrst_ack_driven", bus.rd_ack, 1);
        reset = 1'b1;
        enable = 1'b0;
        cycle();
        chk("midrst_words", word_count, 0);
        chk("midrst_errs", err_count, 0);
        reset = 1'b0;
        bus.rd_ack = 1'b1;
        bus.fifo_dout = 32'h1234_5678;
        cycle();
        chk("late_ack_valid", bus.out_valid, 0);
        chk("late_ack_data", bus.out_data, 0);
        chk("late_ack_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
